latency_monitor: RTL

- Parametrised successor to the single-channel timestamp BRAM latency checker.
- On TX: captures the free-running latency counter into a per-tag timestamp RAM.
- On RX: reads the timestamp back, computes wrap-safe latency, and tracks min/max/sum/count over an armed measurement window.
- Sits between TX_ENGINE (stamp side), RX_ENGINE (completion side) and the VIO/ILA debug fabric.

---
 rtl/latency_monitor_pkg.sv | 33 +++
 rtl/latency_ts_ram.sv | 33 +++
 rtl/latency_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/latency_monitor_pkg.sv
// Shared definitions for the tag-based latency monitor:
// default widths, FSM encoding and a saturating-add helper.
package latency_monitor_pkg;

    localparam int DEF_TS_W  = 48;
    localparam int DEF_TAG_W = 10;
    localparam int DEF_SUM_W = 64;
    localparam int DEF_CNT_W = 32;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns {saturated, result}; result clamps to the all-ones value of width w.
    function automatic logic [MAX_W:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w
    );
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s = {1'b0, a} + {1'b0, b};
        if (w >= MAX_W) lim = {1'b0, {MAX_W{1'b1}}};
        else            lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        if (s >= lim) return {1'b1, lim[MAX_W-1:0]};
        return {1'b0, s[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/latency_ts_ram.sv
// Read-first simple dual-port timestamp RAM, two-cycle read latency
// (array read at the address edge, then an output register).
module latency_ts_ram
    import latency_monitor_pkg::*;
#(
    parameter int DW = DEF_TS_W,
    parameter int AW = DEF_TAG_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_dout;

    // Read sits in the same block as the write so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        r_q <= r_mem[i_raddr];
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        r_dout <= r_q;
    end

    assign o_rdata = r_dout;

endmodule

// File: rtl/latency_monitor.sv
// Per-tag TX->RX latency measurement with windowed min/max/sum/count
// statistics and orphan-completion detection.
module latency_monitor
    import latency_monitor_pkg::*;
#(
    parameter int TS_W  = DEF_TS_W,
    parameter int TAG_W = DEF_TAG_W,
    parameter int SUM_W = DEF_SUM_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TS_W-1:0]  latency_counter,
    input  logic             tx_valid,
    input  logic [TAG_W-1:0] tx_tag,
    input  logic             rx_valid,
    input  logic [TAG_W-1:0] rx_tag,
    input  logic             arm,
    input  logic [CNT_W-1:0] window_len,
    input  logic             stop,
    output logic             lat_valid,
    output logic [TAG_W-1:0] lat_tag,
    output logic [TS_W-1:0]  lat_value,
    output logic             orphan_err,
    output logic [1:0]       state_o,
    output logic [TS_W-1:0]  stat_min,
    output logic [TS_W-1:0]  stat_max,
    output logic [SUM_W-1:0] stat_sum,
    output logic [CNT_W-1:0] stat_count,
    output logic             stat_sat
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0] r_vmap;
    logic             r_p1_v, r_p1_hit, r_p2_v, r_p2_hit;
    logic [TAG_W-1:0] r_p1_tag, r_p2_tag;
    logic [TS_W-1:0]  r_p1_ts, r_p2_ts;
    logic [TS_W-1:0]  w_ram_q;
    logic             w_lat_valid;

    latency_ts_ram #(.DW(TS_W), .AW(TAG_W)) u_ram (
        .clk     (clk),
        .i_we    (tx_valid),
        .i_waddr (tx_tag),
        .i_wdata (latency_counter),
        .i_raddr (rx_tag),
        .o_rdata (w_ram_q)
    );

    // Set after clear: a same-cycle stamp on the completing tag stays live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vmap <= '0;
        end else begin
            if (rx_valid) r_vmap[rx_tag] <= 1'b0;
            if (tx_valid) r_vmap[tx_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_v   <= 1'b0;
            r_p1_hit <= 1'b0;
            r_p1_tag <= '0;
            r_p1_ts  <= '0;
            r_p2_v   <= 1'b0;
            r_p2_hit <= 1'b0;
            r_p2_tag <= '0;
            r_p2_ts  <= '0;
        end else begin
            r_p1_v   <= rx_valid;
            r_p1_hit <= r_vmap[rx_tag];
            r_p1_tag <= rx_tag;
            r_p1_ts  <= latency_counter;
            r_p2_v   <= r_p1_v;
            r_p2_hit <= r_p1_hit;
            r_p2_tag <= r_p1_tag;
            r_p2_ts  <= r_p1_ts;
        end
    end

    assign w_lat_valid = r_p2_v & r_p2_hit;
    assign lat_valid   = w_lat_valid;
    assign orphan_err  = r_p2_v & ~r_p2_hit;
    assign lat_tag     = r_p2_tag;
    assign lat_value   = w_lat_valid ? (r_p2_ts - w_ram_q) : '0;

    state_t           r_state;
    logic [TS_W-1:0]  r_min, r_max;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt, r_win;
    logic             r_sat;
    logic [MAX_W:0]   w_sum_add, w_cnt_add;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_reached;

    assign w_sum_add  = sat_add(MAX_W'(r_sum), MAX_W'(lat_value), SUM_W);
    assign w_cnt_add  = sat_add(MAX_W'(r_cnt), MAX_W'(1), CNT_W);
    assign w_cnt_next = CNT_W'(w_cnt_add);
    assign w_reached  = (r_win != '0) && (w_cnt_next == r_win);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_min   <= '1;
            r_max   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_win   <= '0;
            r_sat   <= 1'b0;
        end else if (arm) begin
            r_state <= ST_ARMED;
            r_min   <= '1;
            r_max   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_win   <= window_len;
            r_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ARMED, ST_RUN: begin
                    // A sample landing with stop is still counted.
                    if (w_lat_valid) begin
                        if (lat_value < r_min) r_min <= lat_value;
                        if (lat_value > r_max) r_max <= lat_value;
                        r_sum <= SUM_W'(w_sum_add);
                        r_cnt <= w_cnt_next;
                        if (w_sum_add[MAX_W] | w_cnt_add[MAX_W]) r_sat <= 1'b1;
                        r_state <= (stop || w_reached) ? ST_DONE : ST_RUN;
                    end else if (stop) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o    = r_state;
    assign stat_min   = r_min;
    assign stat_max   = r_max;
    assign stat_sum   = r_sum;
    assign stat_count = r_cnt;
    assign stat_sat   = r_sat;

endmodule
